// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-side command, write-data and response signals of the memory arbiter.
// The master modport is the arbiter's view; slave is the caches/memory view.
interface mem_arbiter_if #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128
);
    logic                       ic_mem_req_val;
    logic                       ic_mem_req_rdy;
    logic [MEM_ADDR_BITS-1:0]   ic_mem_req_addr;

    logic                       dc_mem_req_val;
    logic                       dc_mem_req_rdy;
    logic [MEM_ADDR_BITS-1:0]   dc_mem_req_addr;
    logic                       dc_mem_req_rw;
    logic                       dc_mem_req_data_valid;
    logic                       dc_mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0]   dc_mem_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] dc_mem_req_data_mask;

    logic                       ic_mem_resp_val;
    logic                       dc_mem_resp_val;
    logic [MEM_DATA_BITS-1:0]   cache_mem_resp_data;

    logic                       mem_req_val;
    logic                       mem_req_rdy;
    logic [MEM_ADDR_BITS-1:0]   mem_req_addr;
    logic                       mem_req_rw;
    logic                       mem_req_data_valid;
    logic                       mem_req_data_ready;
    logic [MEM_DATA_BITS-1:0]   mem_req_data_bits;
    logic [MEM_DATA_BITS/8-1:0] mem_req_data_mask;
    logic                       mem_resp_val;
    logic [MEM_DATA_BITS-1:0]   mem_resp_data;

    modport master (
        input  ic_mem_req_val, ic_mem_req_addr,
        output ic_mem_req_rdy,
        input  dc_mem_req_val, dc_mem_req_addr, dc_mem_req_rw,
        output dc_mem_req_rdy,
        input  dc_mem_req_data_valid, dc_mem_req_data_bits, dc_mem_req_data_mask,
        output dc_mem_req_data_ready,
        output ic_mem_resp_val, dc_mem_resp_val, cache_mem_resp_data,
        output mem_req_val, mem_req_addr, mem_req_rw,
        input  mem_req_rdy,
        output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        input  mem_req_data_ready,
        input  mem_resp_val, mem_resp_data
    );

    modport slave (
        output ic_mem_req_val, ic_mem_req_addr,
        input  ic_mem_req_rdy,
        output dc_mem_req_val, dc_mem_req_addr, dc_mem_req_rw,
        input  dc_mem_req_rdy,
        output dc_mem_req_data_valid, dc_mem_req_data_bits, dc_mem_req_data_mask,
        input  dc_mem_req_data_ready,
        input  ic_mem_resp_val, dc_mem_resp_val, cache_mem_resp_data,
        input  mem_req_val, mem_req_addr, mem_req_rw,
        output mem_req_rdy,
        input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
        output mem_req_data_ready,
        output mem_resp_val, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin icache/dcache arbiter onto one memory port; zero-latency command/response pass-through,
// read responses steered by an owner FIFO, dcache writeback data phase locks the port until all beats move.
module mem_arbiter #(
    parameter int MEM_ADDR_BITS = 28,
    parameter int MEM_DATA_BITS = 128,
    parameter int DATA_CYCLES   = 4,
    parameter int OUTSTANDING   = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master io_bus
);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);
    localparam int BW = $clog2(DATA_CYCLES + 1);

    typedef enum logic {S_IDLE, S_WDATA} state_t;

    state_t                 r_state;
    logic                   r_last_dc;
    logic [BW-1:0]          r_wbeat;
    logic [BW-1:0]          r_rbeat;
    logic [OUTSTANDING-1:0] r_owner;
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;

    logic w_idle, w_in_wdata, w_full, w_empty;
    logic w_ic_req, w_dc_req, w_gnt_ic, w_gnt_dc, w_rw;
    logic w_cmd_fire, w_push, w_wr_fire, w_data_fire;
    logic w_head_dc, w_beat_ok, w_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_idle     = !reset && (r_state == S_IDLE);
    assign w_in_wdata = !reset && (r_state == S_WDATA);
    assign w_full     = (r_count == CW'(OUTSTANDING));
    assign w_empty    = (r_count == '0);

    // A full owner FIFO blocks reads only; a dcache write can still win.
    assign w_ic_req = io_bus.ic_mem_req_val && !w_full;
    assign w_dc_req = io_bus.dc_mem_req_val && (io_bus.dc_mem_req_rw || !w_full);
    assign w_gnt_dc = w_idle && w_dc_req && (!w_ic_req || !r_last_dc);
    assign w_gnt_ic = w_idle && w_ic_req && !w_gnt_dc;
    assign w_rw     = w_gnt_dc && io_bus.dc_mem_req_rw;

    assign io_bus.mem_req_val    = w_gnt_dc || w_gnt_ic;
    assign io_bus.mem_req_addr   = w_gnt_dc ? io_bus.dc_mem_req_addr : io_bus.ic_mem_req_addr;
    assign io_bus.mem_req_rw     = w_rw;
    assign io_bus.dc_mem_req_rdy = w_gnt_dc && io_bus.mem_req_rdy;
    assign io_bus.ic_mem_req_rdy = w_gnt_ic && io_bus.mem_req_rdy;

    assign w_cmd_fire = io_bus.mem_req_val && io_bus.mem_req_rdy;
    assign w_push     = w_cmd_fire && !w_rw;
    assign w_wr_fire  = w_cmd_fire && w_rw;

    assign io_bus.mem_req_data_valid    = w_in_wdata && io_bus.dc_mem_req_data_valid;
    assign io_bus.dc_mem_req_data_ready = w_in_wdata && io_bus.mem_req_data_ready;
    assign io_bus.mem_req_data_bits     = io_bus.dc_mem_req_data_bits;
    assign io_bus.mem_req_data_mask     = io_bus.dc_mem_req_data_mask;
    assign w_data_fire = w_in_wdata && io_bus.dc_mem_req_data_valid && io_bus.mem_req_data_ready;

    // Beats arriving with no read outstanding are dropped rather than steered.
    assign w_head_dc = r_owner[r_rd_ptr];
    assign w_beat_ok = !reset && io_bus.mem_resp_val && !w_empty;
    assign w_pop     = w_beat_ok && (r_rbeat == BW'(DATA_CYCLES - 1));

    assign io_bus.cache_mem_resp_data = io_bus.mem_resp_data;
    assign io_bus.ic_mem_resp_val     = w_beat_ok && !w_head_dc;
    assign io_bus.dc_mem_resp_val     = w_beat_ok && w_head_dc;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_last_dc <= 1'b0;
            r_wbeat   <= '0;
            r_rbeat   <= '0;
            r_owner   <= '0;
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_fire) begin
                        r_state <= S_WDATA;
                        r_wbeat <= '0;
                    end
                end
                S_WDATA: begin
                    if (w_data_fire) begin
                        if (r_wbeat == BW'(DATA_CYCLES - 1)) begin
                            r_state <= S_IDLE;
                            r_wbeat <= '0;
                        end else begin
                            r_wbeat <= r_wbeat + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_cmd_fire) r_last_dc <= w_gnt_dc;

            if (w_push) begin
                r_owner[r_wr_ptr] <= w_gnt_dc;
                r_wr_ptr          <= ptr_next(r_wr_ptr);
            end

            if (w_beat_ok) r_rbeat <= w_pop ? '0 : r_rbeat + 1'b1;
            if (w_pop)     r_rd_ptr <= ptr_next(r_rd_ptr);

            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    a_resp_while_empty: assert property (@(posedge clk) disable iff (reset)
        !(io_bus.mem_resp_val && w_empty));
endmodule
